// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: shared definitions for the HI/LO multiply/divide unit.
// Holds the op_i encodings, the FSM state encodings, the divider handshake
// constants and a small opcode classification helper.
package hilo_mdu_pkg;

  // op_i encodings
  typedef enum logic [3:0] {
    MDU_OP_MULT  = 4'd0,
    MDU_OP_MULTU = 4'd1,
    MDU_OP_MADD  = 4'd2,
    MDU_OP_MADDU = 4'd3,
    MDU_OP_MSUB  = 4'd4,
    MDU_OP_MSUBU = 4'd5,
    MDU_OP_DIV   = 4'd6,
    MDU_OP_DIVU  = 4'd7,
    MDU_OP_MTHI  = 4'd8,
    MDU_OP_MTLO  = 4'd9
  } mdu_op_e;

  // Engine states; the divider core reuses IDLE/DIV/FIX for its own sequencing
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_ACC  = 3'd2,
    ST_DIV  = 3'd3,
    ST_FIX  = 3'd4
  } mdu_state_e;

  // Divider result handshake levels
  localparam logic DivResultReady = 1'b1;
  localparam logic Stop           = 1'b0;

  // True for the opcodes that treat their operands as two's complement
  function automatic logic mdu_op_signed(input mdu_op_e op);
    logic s;
    case (op)
      MDU_OP_MULT, MDU_OP_MADD, MDU_OP_MSUB, MDU_OP_DIV: s = 1'b1;
      default:                                          s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative restoring divider for hilo_mdu.
// Captures operand magnitudes on start, produces one quotient bit per cycle
// for WIDTH cycles, then spends one cycle in FIX where the sign-corrected
// quotient/remainder are presented with ready_o high.
module mdu_div_core
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e       st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] r_q, r_d;      // partial remainder
  logic [WIDTH-1:0] d_q, d_d;      // divisor magnitude
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;

  // Trial subtraction for the current quotient bit
  always_comb begin
    shift_s = {r_q, q_q[WIDTH-1]};
    diff_s  = shift_s - {1'b0, d_q};
  end

  // Next-state logic: capture magnitudes, iterate, then one fix cycle
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    d_d    = d_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    case (st_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          q_d    = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
          d_d    = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
          r_d    = '0;
          qneg_d = signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          rneg_d = signed_i && dividend_i[WIDTH-1];
          cnt_d  = CW'(WIDTH - 1);
          st_d   = ST_DIV;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          st_d = ST_IDLE;
        end else begin
          if (!diff_s[WIDTH]) begin
            r_d = diff_s[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = shift_s[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            st_d = ST_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_FIX: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // Divider state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      r_q    <= r_d;
      d_q    <= d_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  // Handshake and sign-restored results, decoded from registered state
  always_comb begin
    last_o  = (st_q == ST_DIV) && (cnt_q == '0);
    ready_o = (st_q == ST_FIX) ? DivResultReady : Stop;
    quot_o  = qneg_q ? -q_q : q_q;
    rem_o   = rneg_q ? -r_q : r_q;
  end

endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle multiply/divide unit that owns the HI/LO pair.
// start/busy/done handshake; flush annuls the in-flight operation.
// Build option: define HILO_MDU_MACC_EN to support MADD/MADDU/MSUB/MSUBU
// accumulation (ACC state + 2*WIDTH adder). Without it those opcodes behave
// as MULT/MULTU and overwrite HI/LO.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_e       state_q, state_d;
  logic [MCW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
`ifdef HILO_MDU_MACC_EN
  logic             acc_q, acc_d;  // MADD/MSUB family: go through ACC
  logic             sub_q, sub_d;  // MSUB family: subtract the product
`endif

  mdu_op_e            op_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s;
  logic [2*WIDTH-1:0] mag_p_s, prod_s;
  logic               prod_neg_s;

  logic               div_start_s;
  logic               div_signed_s;
  logic               div_last_s;
  logic               div_ready_s;
  logic [WIDTH-1:0]   div_quot_s, div_rem_s;

  // Magnitude multiply of the captured operands with sign restore
  always_comb begin
    mag_a_s    = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b_s    = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    mag_p_s    = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
    prod_neg_s = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    prod_s     = prod_neg_s ? -mag_p_s : mag_p_s;
  end

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start_s),
    .flush_i    (flush_i),
    .signed_i   (div_signed_s),
    .dividend_i (opa_i),
    .divisor_i  (opb_i),
    .last_o     (div_last_s),
    .ready_o    (div_ready_s),
    .quot_o     (div_quot_s),
    .rem_o      (div_rem_s)
  );

  // Engine next-state: accept, sequence, and compute the HI/LO update
  always_comb begin
    op_s         = mdu_op_e'(op_i);
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    sgn_d        = sgn_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    dbz_d        = 1'b0;
    div_start_s  = 1'b0;
    div_signed_s = mdu_op_signed(op_s);
`ifdef HILO_MDU_MACC_EN
    acc_d        = acc_q;
    sub_d        = sub_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          case (op_s)
            MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_MADD,
            MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU: begin
              a_d     = opa_i;
              b_d     = opb_i;
              sgn_d   = mdu_op_signed(op_s);
              cnt_d   = MCW'(MUL_LAT - 1);
              state_d = ST_MUL;
`ifdef HILO_MDU_MACC_EN
              acc_d   = (op_s != MDU_OP_MULT) && (op_s != MDU_OP_MULTU);
              sub_d   = (op_s == MDU_OP_MSUB) || (op_s == MDU_OP_MSUBU);
`endif
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
              if (opb_i == '0) begin
                // Divide by zero completes at once and leaves HI/LO alone
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                div_start_s = 1'b1;
                state_d     = ST_DIV;
              end
            end
            MDU_OP_MTHI: begin
              hi_d   = opa_i;
              done_d = 1'b1;
            end
            MDU_OP_MTLO: begin
              lo_d   = opa_i;
              done_d = 1'b1;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
`ifdef HILO_MDU_MACC_EN
          if (acc_q) begin
            state_d = ST_ACC;
          end else begin
            {hi_d, lo_d} = prod_s;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
          end
`else
          {hi_d, lo_d} = prod_s;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - MCW'(1);
        end
      end
`ifdef HILO_MDU_MACC_EN
      ST_ACC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          if (sub_q) begin
            {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
          end else begin
            {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      ST_DIV: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (div_last_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIX: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (div_ready_s == DivResultReady) begin
          lo_d    = div_quot_s;
          hi_d    = div_rem_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Engine registers, HI/LO and registered completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef HILO_MDU_MACC_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef HILO_MDU_MACC_EN
      acc_q   <= acc_d;
      sub_q   <= sub_d;
`endif
    end
  end

  // Busy is decoded from state so the execute stage can stall in the same cycle
  always_comb begin
    busy_o = (state_q != ST_IDLE);
    done_o = done_q;
    dbz_o  = dbz_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: self-checking bench for hilo_mdu (directed + random ops
// against a plain-arithmetic HI/LO model). Honours HILO_MDU_MACC_EN.
`timescale 1ns/1ps
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = WIDTH + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] opa_i = 32'd0;
  logic [31:0] opb_i = 32'd0;
  logic        busy_o, done_o, dbz_o;
  logic [31:0] hi_o, lo_o;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i),
    .opb_i(opb_i), .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
    .dbz_o(dbz_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO update, expected latency and divide-by-zero flag
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic dbz);
    logic [63:0] hl, pu, ps;
    int sa, sb;
    hl  = {hi_m, lo_m};
    pu  = {32'h0, a} * {32'h0, b};
    ps  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    dbz = 1'b0;
    lat = MUL_LAT + 1;
    case (mdu_op_e'(op))
      MDU_OP_MULT:  hl = ps;
      MDU_OP_MULTU: hl = pu;
`ifdef HILO_MDU_MACC_EN
      MDU_OP_MADD:  begin hl = hl + ps; lat = MUL_LAT + 2; end
      MDU_OP_MADDU: begin hl = hl + pu; lat = MUL_LAT + 2; end
      MDU_OP_MSUB:  begin hl = hl - ps; lat = MUL_LAT + 2; end
      MDU_OP_MSUBU: begin hl = hl - pu; lat = MUL_LAT + 2; end
`else
      MDU_OP_MADD, MDU_OP_MSUB:   hl = ps;
      MDU_OP_MADDU, MDU_OP_MSUBU: hl = pu;
`endif
      MDU_OP_DIV: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin
          dbz = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hl = {32'h0, 32'h8000_0000};
        end else begin
          sa = a; sb = b;
          hl = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      MDU_OP_DIVU: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin
          dbz = 1'b1; lat = 1;
        end else begin
          hl = {a % b, a / b};
        end
      end
      MDU_OP_MTHI: begin hl[63:32] = a; lat = 1; end
      MDU_OP_MTLO: begin hl[31:0]  = a; lat = 1; end
      default: lat = 1;
    endcase
    hi_m = hl[63:32];
    lo_m = hl[31:0];
  endtask

  // Issue one op (caller is idle, before an edge) and check its completion
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int   lat, cyc;
    logic dbz;
    bit   seen;
    model(op, a, b, lat, dbz);
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    seen = 1'b0;
    cyc  = 1;
    while (!seen && cyc <= 60) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
      end else begin
        chk({tag, "/busy"}, 64'(busy_o), 64'(1'b1));
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "/done_seen"}, 64'(seen), 64'(1'b1));
    chk({tag, "/latency"}, 64'(cyc), 64'(lat));
    chk({tag, "/hi"}, 64'(hi_o), 64'(hi_m));
    chk({tag, "/lo"}, 64'(lo_o), 64'(lo_m));
    chk({tag, "/dbz"}, 64'(dbz_o), 64'(dbz));
    chk({tag, "/busy_at_done"}, 64'(busy_o), 64'(1'b0));
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] h0, l0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst/busy", 64'(busy_o), 64'(1'b0));
    chk("rst/done", 64'(done_o), 64'(1'b0));
    chk("rst/dbz",  64'(dbz_o),  64'(1'b0));
    chk("rst/hi",   64'(hi_o),   64'd0);
    chk("rst/lo",   64'(lo_o),   64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(MDU_OP_MULT, 32'hFFFF_FFFF, 32'h2, "mult");
    chk("mult/hi_const", 64'(hi_o), 64'(32'hFFFF_FFFF));
    chk("mult/lo_const", 64'(lo_o), 64'(32'hFFFF_FFFE));
    run_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'h2, "multu");
    chk("multu/hi_const", 64'(hi_o), 64'(32'h1));
    run_op(MDU_OP_DIV, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
    chk("div_m7_2/lo_const", 64'(lo_o), 64'(32'hFFFF_FFFD));
    chk("div_m7_2/hi_const", 64'(hi_o), 64'(32'hFFFF_FFFF));
    run_op(MDU_OP_DIVU, 32'h8000_0000, 32'h3, "divu");
    chk("divu/lo_const", 64'(lo_o), 64'(32'h2AAA_AAAA));
    chk("divu/hi_const", 64'(hi_o), 64'(32'h2));
    run_op(MDU_OP_MTHI, 32'h0, 32'h0, "mthi0");
    run_op(MDU_OP_MTLO, 32'd10, 32'h0, "mtlo10");
    run_op(MDU_OP_MADD, 32'd3, 32'd4, "madd");
`ifdef HILO_MDU_MACC_EN
    chk("madd/lo_const", 64'(lo_o), 64'd22);
`else
    chk("madd/lo_const", 64'(lo_o), 64'd12);
`endif
    run_op(MDU_OP_MSUB, 32'd5, 32'd5, "msub");
`ifdef HILO_MDU_MACC_EN
    chk("msub/lo_const", 64'(lo_o), 64'(32'hFFFF_FFFD));
    chk("msub/hi_const", 64'(hi_o), 64'(32'hFFFF_FFFF));
`else
    chk("msub/lo_const", 64'(lo_o), 64'd25);
`endif
    run_op(MDU_OP_DIV, 32'd1234, 32'd0, "div_by_zero");
    run_op(MDU_OP_DIVU, 32'd99, 32'd0, "divu_by_zero");
    run_op(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
    chk("div_minneg/lo_const", 64'(lo_o), 64'(32'h8000_0000));
    // MULT then DIV issued in the MULT done cycle
    run_op(MDU_OP_MULT, 32'd7, 32'hFFFF_FFFD, "b2b_mult");
    run_op(MDU_OP_DIV, 32'd1000, 32'hFFFF_FFF9, "b2b_div");

    // Flush mid-DIV while start_i stays high with an MTHI
    h0 = hi_m; l0 = lo_m;
    op_i = MDU_OP_DIV; opa_i = 32'd100; opb_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    op_i = MDU_OP_MTHI; opa_i = 32'hDEAD_BEEF;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      chk("flush/busy_before", 64'(busy_o), 64'(1'b1));
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("flush/busy_after", 64'(busy_o), 64'(1'b0));
    for (int k = 0; k < 40; k++) begin
      chk("flush/no_done", 64'(done_o), 64'(1'b0));
      @(negedge clk);
    end
    chk("flush/hi", 64'(hi_o), 64'(h0));
    chk("flush/lo", 64'(lo_o), 64'(l0));

    // flush_i together with start_i in IDLE drops the start
    op_i = MDU_OP_MTHI; opa_i = 32'h1234_5678; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_start/done", 64'(done_o), 64'(1'b0));
    chk("flush_start/busy", 64'(busy_o), 64'(1'b0));
    chk("flush_start/hi", 64'(hi_o), 64'(h0));

    // Randomized ops, mostly back-to-back, sometimes with idle gaps
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 9)), rnd_val(), rnd_val(), "rand");
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Reset mid-DIV clears everything at the next edge
    run_op(MDU_OP_MTHI, 32'hA5A5_0001, 32'h0, "pre_rst_hi");
    run_op(MDU_OP_MTLO, 32'h5A5A_0002, 32'h0, "pre_rst_lo");
    op_i = MDU_OP_DIV; opa_i = 32'd77; opb_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    chk("midrst/busy", 64'(busy_o), 64'(1'b0));
    chk("midrst/done", 64'(done_o), 64'(1'b0));
    chk("midrst/dbz",  64'(dbz_o),  64'(1'b0));
    chk("midrst/hi",   64'(hi_o),   64'd0);
    chk("midrst/lo",   64'(lo_o),   64'd0);
    run_op(MDU_OP_DIVU, 32'd77, 32'd5, "post_rst_div");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
